// File: rtl/bp_me_bedrock_register_master.sv
// rtl/bp_me_bedrock_register_master.sv - single-outstanding register port to BedRock stream command/response bridge
module bp_me_bedrock_register_master
  #(parameter int paddr_width_p      = 40
   ,parameter int payload_width_p    = 16
   ,parameter int reg_width_p        = 64
   ,parameter int reg_addr_width_p   = paddr_width_p
   ,localparam int lg_reg_width_lp   = $clog2($clog2(reg_width_p/8) + 1)
   ,localparam int mem_header_width_lp = payload_width_p + 3 + paddr_width_p + 4 + 4
   )
   (input  logic                           clk_i
   ,input  logic                           reset_n_i

   ,input  logic                           v_i
   ,output logic                           ready_and_o
   ,input  logic                           w_i
   ,input  logic [reg_addr_width_p-1:0]    addr_i
   ,input  logic [lg_reg_width_lp-1:0]     size_i
   ,input  logic [reg_width_p-1:0]         data_i

   ,output logic                           v_o
   ,input  logic                           ready_and_i
   ,output logic [reg_width_p-1:0]         data_o

   ,output logic [mem_header_width_lp-1:0] mem_cmd_header_o
   ,output logic                           mem_cmd_header_v_o
   ,input  logic                           mem_cmd_header_ready_and_i
   ,output logic                           mem_cmd_has_data_o
   ,output logic [63:0]                    mem_cmd_data_o
   ,output logic                           mem_cmd_data_v_o
   ,input  logic                           mem_cmd_data_ready_and_i
   ,output logic                           mem_cmd_last_o

   ,input  logic [mem_header_width_lp-1:0] mem_resp_header_i
   ,input  logic                           mem_resp_header_v_i
   ,output logic                           mem_resp_header_ready_and_o
   ,input  logic                           mem_resp_has_data_i
   ,input  logic [63:0]                    mem_resp_data_i
   ,input  logic                           mem_resp_data_v_i
   ,output logic                           mem_resp_data_ready_and_o
   ,input  logic                           mem_resp_last_i
   );

   // The data path assumes exactly one dword beat per message.
   if (reg_width_p != 64) begin : g_width_err
      $error("reg_width_p must equal the 64-bit dword width");
   end
   if (reg_addr_width_p > paddr_width_p) begin : g_addr_err
      $error("reg_addr_width_p must not exceed paddr_width_p");
   end

   localparam logic [3:0] e_bedrock_mem_uc_rd = 4'd2;
   localparam logic [3:0] e_bedrock_mem_uc_wr = 4'd3;

   localparam logic [2:0] e_ready            = 3'd0;
   localparam logic [2:0] e_send_header      = 3'd1;
   localparam logic [2:0] e_send_data        = 3'd2;
   localparam logic [2:0] e_wait_resp_header = 3'd3;
   localparam logic [2:0] e_wait_resp_data   = 3'd4;
   localparam logic [2:0] e_return           = 3'd5;

   logic [2:0]                   state_q, state_d;
   logic                         w_q, w_d;
   logic [reg_addr_width_p-1:0]  addr_q, addr_d;
   logic [lg_reg_width_lp-1:0]   size_q, size_d;
   logic [reg_width_p-1:0]       data_q, data_d;
   logic [reg_width_p-1:0]       rdata_q, rdata_d;

   logic [63:0]                  cmd_data;
   logic [63:0]                  size_mask;
   logic [paddr_width_p-1:0]     hdr_addr;
   logic [3:0]                   hdr_msg_type;

   // The response header contents carry nothing this bridge needs.
   logic unused_resp_header;
   assign unused_resp_header = ^mem_resp_header_i;

   // Narrow writes replicate the active bytes across the beat; reads keep only the active bytes.
   always_comb begin
      cmd_data  = data_q;
      size_mask = '1;
      case (size_q)
         lg_reg_width_lp'(0): begin
            cmd_data  = {8{data_q[7:0]}};
            size_mask = 64'h0000_0000_0000_00FF;
         end
         lg_reg_width_lp'(1): begin
            cmd_data  = {4{data_q[15:0]}};
            size_mask = 64'h0000_0000_0000_FFFF;
         end
         lg_reg_width_lp'(2): begin
            cmd_data  = {2{data_q[31:0]}};
            size_mask = 64'h0000_0000_FFFF_FFFF;
         end
         default: begin
            cmd_data  = data_q;
            size_mask = '1;
         end
      endcase
   end

   assign hdr_addr     = paddr_width_p'(addr_q);
   assign hdr_msg_type = w_q ? e_bedrock_mem_uc_wr : e_bedrock_mem_uc_rd;

   // Header is {payload, size, addr, subop, msg_type}, msg_type in the low bits.
   assign mem_cmd_header_o = {{payload_width_p{1'b0}}, 3'(size_q), hdr_addr, 4'b0000, hdr_msg_type};

   // All handshake outputs decode from registered state only.
   assign ready_and_o                 = (state_q == e_ready);
   assign mem_cmd_header_v_o          = (state_q == e_send_header);
   assign mem_cmd_data_v_o            = (state_q == e_send_data);
   assign mem_cmd_last_o              = mem_cmd_data_v_o;
   assign mem_cmd_has_data_o          = w_q;
   assign mem_cmd_data_o              = cmd_data;
   assign mem_resp_header_ready_and_o = (state_q == e_wait_resp_header);
   assign mem_resp_data_ready_and_o   = (state_q == e_wait_resp_data);
   assign v_o                         = (state_q == e_return);
   assign data_o                      = rdata_q;

   // Transaction sequencing and request/response capture.
   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      addr_d  = addr_q;
      size_d  = size_q;
      data_d  = data_q;
      rdata_d = rdata_q;
      case (state_q)
         e_ready: begin
            if (v_i) begin
               w_d     = w_i;
               addr_d  = addr_i;
               size_d  = size_i;
               data_d  = data_i;
               state_d = e_send_header;
            end
         end
         e_send_header: begin
            if (mem_cmd_header_ready_and_i) begin
               state_d = w_q ? e_send_data : e_wait_resp_header;
            end
         end
         e_send_data: begin
            if (mem_cmd_data_ready_and_i) begin
               state_d = e_wait_resp_header;
            end
         end
         e_wait_resp_header: begin
            if (mem_resp_header_v_i) begin
               if (mem_resp_has_data_i) begin
                  state_d = e_wait_resp_data;
               end else begin
                  rdata_d = '0;
                  state_d = e_return;
               end
            end
         end
         e_wait_resp_data: begin
            if (mem_resp_data_v_i) begin
               // Write responses with data are drained; only reads return bytes.
               rdata_d = w_q ? '0 : (mem_resp_data_i & size_mask);
               if (mem_resp_last_i) begin
                  state_d = e_return;
               end
            end
         end
         e_return: begin
            if (ready_and_i) begin
               state_d = e_ready;
            end
         end
         default: state_d = e_ready;
      endcase
   end

   // State and latched request registers; reset abandons any transaction.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= e_ready;
         w_q     <= 1'b0;
         addr_q  <= '0;
         size_q  <= '0;
         data_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         data_q  <= data_d;
         rdata_q <= rdata_d;
      end
   end

endmodule

// File: tb/tb_bp_me_bedrock_register_master.sv
// tb/tb_bp_me_bedrock_register_master.sv - randomized self-checking bench for the register master bridge
module tb_bp_me_bedrock_register_master;

   localparam int PAW = 40;
   localparam int HW  = 16 + 3 + PAW + 4 + 4;

   logic          clk_i = 1'b0;
   logic          reset_n_i;
   logic          v_i, ready_and_o, w_i;
   logic [PAW-1:0] addr_i;
   logic [1:0]    size_i;
   logic [63:0]   data_i;
   logic          v_o, ready_and_i;
   logic [63:0]   data_o;
   logic [HW-1:0] mem_cmd_header_o;
   logic          mem_cmd_header_v_o, mem_cmd_header_ready_and_i, mem_cmd_has_data_o;
   logic [63:0]   mem_cmd_data_o;
   logic          mem_cmd_data_v_o, mem_cmd_data_ready_and_i, mem_cmd_last_o;
   logic [HW-1:0] mem_resp_header_i;
   logic          mem_resp_header_v_i, mem_resp_header_ready_and_o, mem_resp_has_data_i;
   logic [63:0]   mem_resp_data_i;
   logic          mem_resp_data_v_i, mem_resp_data_ready_and_o, mem_resp_last_i;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk_i = ~clk_i;

   bp_me_bedrock_register_master dut
     (.clk_i(clk_i), .reset_n_i(reset_n_i)
     ,.v_i(v_i), .ready_and_o(ready_and_o), .w_i(w_i), .addr_i(addr_i), .size_i(size_i), .data_i(data_i)
     ,.v_o(v_o), .ready_and_i(ready_and_i), .data_o(data_o)
     ,.mem_cmd_header_o(mem_cmd_header_o), .mem_cmd_header_v_o(mem_cmd_header_v_o)
     ,.mem_cmd_header_ready_and_i(mem_cmd_header_ready_and_i), .mem_cmd_has_data_o(mem_cmd_has_data_o)
     ,.mem_cmd_data_o(mem_cmd_data_o), .mem_cmd_data_v_o(mem_cmd_data_v_o)
     ,.mem_cmd_data_ready_and_i(mem_cmd_data_ready_and_i), .mem_cmd_last_o(mem_cmd_last_o)
     ,.mem_resp_header_i(mem_resp_header_i), .mem_resp_header_v_i(mem_resp_header_v_i)
     ,.mem_resp_header_ready_and_o(mem_resp_header_ready_and_o), .mem_resp_has_data_i(mem_resp_has_data_i)
     ,.mem_resp_data_i(mem_resp_data_i), .mem_resp_data_v_i(mem_resp_data_v_i)
     ,.mem_resp_data_ready_and_o(mem_resp_data_ready_and_o), .mem_resp_last_i(mem_resp_last_i)
     );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Reference: byte i of the beat is byte (i mod 2^size) of the request data.
   function automatic logic [63:0] model_cmd_data(input logic [63:0] d, input int sz);
      logic [63:0] r;
      int nb;
      nb = 1 << sz;
      r  = '0;
      for (int i = 0; i < 8; i++) r[8*i +: 8] = d[8*(i % nb) +: 8];
      return r;
   endfunction

   // Reference: read data keeps the low 2^size bytes.
   function automatic logic [63:0] model_rd_data(input logic [63:0] d, input int sz);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < (1 << sz); i++) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   task automatic idle_inputs();
      v_i = 1'b0; w_i = 1'b0; addr_i = '0; size_i = '0; data_i = '0; ready_and_i = 1'b0;
      mem_cmd_header_ready_and_i = 1'b0; mem_cmd_data_ready_and_i = 1'b0;
      mem_resp_header_i = '0; mem_resp_header_v_i = 1'b0; mem_resp_has_data_i = 1'b0;
      mem_resp_data_i = '0; mem_resp_data_v_i = 1'b0; mem_resp_last_i = 1'b0;
   endtask

   task automatic check_header(input logic w, input logic [PAW-1:0] a, input logic [1:0] sz);
      check("hdr_msg_type", 64'(mem_cmd_header_o[3:0]), w ? 64'd3 : 64'd2);
      check("hdr_subop", 64'(mem_cmd_header_o[7:4]), 64'd0);
      check("hdr_addr", 64'(mem_cmd_header_o[47:8]), 64'(a));
      check("hdr_size", 64'(mem_cmd_header_o[50:48]), 64'(sz));
      check("hdr_payload", 64'(mem_cmd_header_o[66:51]), 64'd0);
      check("has_data", 64'(mem_cmd_has_data_o), 64'(w));
   endtask

   // One complete transaction with the bench acting as agent and memory.
   task automatic run_txn(input logic w, input logic [PAW-1:0] a, input logic [1:0] sz,
                          input logic [63:0] d, input logic rhd, input logic [63:0] rd, input int stall);
      int lat;
      int nbeats;
      logic [63:0] exp_rd;
      exp_rd = (w || !rhd) ? 64'd0 : model_rd_data(rd, int'(sz));
      check("req_ready", 64'(ready_and_o), 64'd1);
      v_i = 1'b1; w_i = w; addr_i = a; size_i = sz; data_i = d;
      tick();
      v_i = 1'b0; w_i = ~w; addr_i = PAW'({$urandom, $urandom}); size_i = 2'($urandom); data_i = {$urandom, $urandom};
      check("busy_ready", 64'(ready_and_o), 64'd0);
      lat = -1;
      for (int k = 0; k < 100 && lat < 0; k++) begin
         mem_cmd_header_ready_and_i = (stall == 0) || ($urandom_range(0, stall) == 0);
         if (mem_cmd_header_v_o && mem_cmd_header_ready_and_i) lat = k;
         else tick();
      end
      if (lat < 0) check("hdr_timeout", 64'd0, 64'd1);
      else begin
         check_header(w, a, sz);
         if (stall == 0) check("hdr_latency", 64'(lat), 64'd0);
      end
      tick();
      mem_cmd_header_ready_and_i = 1'b0;
      if (w) begin
         lat = -1;
         for (int k = 0; k < 100 && lat < 0; k++) begin
            mem_cmd_data_ready_and_i = (stall == 0) || ($urandom_range(0, stall) == 0);
            if (mem_cmd_data_v_o && mem_cmd_data_ready_and_i) lat = k;
            else tick();
         end
         if (lat < 0) check("data_timeout", 64'd0, 64'd1);
         else begin
            check("cmd_data", mem_cmd_data_o, model_cmd_data(d, int'(sz)));
            check("cmd_last", 64'(mem_cmd_last_o), 64'd1);
            if (stall == 0) check("data_latency", 64'(lat), 64'd0);
         end
         tick();
         mem_cmd_data_ready_and_i = 1'b0;
      end else begin
         check("rd_no_data_beat", 64'(mem_cmd_data_v_o), 64'd0);
      end
      mem_resp_header_v_i = 1'b1; mem_resp_has_data_i = rhd;
      mem_resp_header_i = HW'({$urandom, $urandom, $urandom});
      lat = -1;
      for (int k = 0; k < 100 && lat < 0; k++) begin
         if (mem_resp_header_ready_and_o) lat = k;
         else tick();
      end
      if (lat < 0) check("resp_hdr_timeout", 64'd0, 64'd1);
      tick();
      mem_resp_header_v_i = 1'b0; mem_resp_has_data_i = 1'b0;
      nbeats = rhd ? (w ? 2 : 1) : 0;
      for (int b = 0; b < nbeats; b++) begin
         mem_resp_data_v_i = 1'b1;
         mem_resp_last_i   = (b == nbeats - 1);
         mem_resp_data_i   = (b == nbeats - 1) ? rd : {$urandom, $urandom};
         lat = -1;
         for (int k = 0; k < 100 && lat < 0; k++) begin
            if (mem_resp_data_ready_and_o) lat = k;
            else tick();
         end
         if (lat < 0) check("resp_data_timeout", 64'd0, 64'd1);
         tick();
      end
      mem_resp_data_v_i = 1'b0; mem_resp_last_i = 1'b0;
      lat = -1;
      for (int k = 0; k < 100 && lat < 0; k++) begin
         ready_and_i = (stall == 0) || ($urandom_range(0, stall) == 0);
         if (v_o && ready_and_i) lat = k;
         else tick();
      end
      if (lat < 0) check("resp_timeout", 64'd0, 64'd1);
      else begin
         check("resp_data", data_o, exp_rd);
         if (stall == 0) check("resp_latency", 64'(lat), 64'd0);
      end
      tick();
      ready_and_i = 1'b0;
      check("back_to_ready", 64'(ready_and_o), 64'd1);
   endtask

   initial begin
      logic [HW-1:0] hdr0;
      idle_inputs();
      reset_n_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_ready_and_o", 64'(ready_and_o), 64'd1);
      check("rst_v_o", 64'(v_o), 64'd0);
      check("rst_hdr_v", 64'(mem_cmd_header_v_o), 64'd0);
      check("rst_data_v", 64'(mem_cmd_data_v_o), 64'd0);
      check("rst_resp_rdy", 64'({mem_resp_header_ready_and_o, mem_resp_data_ready_and_o}), 64'd0);
      check("rst_data_o", data_o, 64'd0);
      #3 reset_n_i = 1'b1;
      tick();

      // Zero-wait directed transactions.
      run_txn(1'b1, 40'h10, 2'd3, 64'hDEADBEEF_CAFEF00D, 1'b0, 64'd0, 0);
      run_txn(1'b1, 40'h18, 2'd0, 64'h0000_0000_0000_00A5, 1'b0, 64'd0, 0);
      check("a5_model", model_cmd_data(64'hA5, 0), 64'hA5A5A5A5_A5A5A5A5);
      run_txn(1'b0, 40'h20, 2'd2, 64'd0, 1'b1, 64'h11223344_55667788, 0);

      // Header backpressure then response backpressure on a 2B read.
      v_i = 1'b1; w_i = 1'b0; addr_i = 40'h34; size_i = 2'd1; data_i = '0;
      tick();
      v_i = 1'b0;
      hdr0 = mem_cmd_header_o;
      for (int c = 0; c < 5; c++) begin
         check("bp_hdr_v", 64'(mem_cmd_header_v_o), 64'd1);
         check("bp_hdr_stable", 64'(mem_cmd_header_o == hdr0), 64'd1);
         check("bp_not_ready", 64'(ready_and_o), 64'd0);
         tick();
      end
      check_header(1'b0, 40'h34, 2'd1);
      mem_cmd_header_ready_and_i = 1'b1;
      tick();
      mem_cmd_header_ready_and_i = 1'b0;
      mem_resp_header_v_i = 1'b1; mem_resp_has_data_i = 1'b1;
      tick();
      mem_resp_header_v_i = 1'b0; mem_resp_has_data_i = 1'b0;
      mem_resp_data_v_i = 1'b1; mem_resp_last_i = 1'b1; mem_resp_data_i = 64'h01234567_89ABCDEF;
      tick();
      mem_resp_data_v_i = 1'b0; mem_resp_last_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check("bp_v_o", 64'(v_o), 64'd1);
         check("bp_data_o", data_o, model_rd_data(64'h01234567_89ABCDEF, 1));
         check("bp_ret_not_ready", 64'(ready_and_o), 64'd0);
         tick();
      end
      ready_and_i = 1'b1;
      tick();
      ready_and_i = 1'b0;
      check("bp_done", 64'(ready_and_o), 64'd1);

      // Response header arriving while the data beat is still stalled.
      v_i = 1'b1; w_i = 1'b1; addr_i = 40'h40; size_i = 2'd3; data_i = 64'h5555_AAAA_5555_AAAA;
      tick();
      v_i = 1'b0;
      mem_cmd_header_ready_and_i = 1'b1;
      tick();
      mem_cmd_header_ready_and_i = 1'b0;
      mem_resp_header_v_i = 1'b1; mem_resp_has_data_i = 1'b0;
      for (int c = 0; c < 2; c++) begin
         check("early_resp_stalled", 64'(mem_resp_header_ready_and_o), 64'd0);
         check("early_data_v", 64'(mem_cmd_data_v_o), 64'd1);
         tick();
      end
      mem_cmd_data_ready_and_i = 1'b1;
      tick();
      mem_cmd_data_ready_and_i = 1'b0;
      check("early_resp_accept", 64'(mem_resp_header_ready_and_o), 64'd1);
      tick();
      mem_resp_header_v_i = 1'b0;
      check("early_v_o", 64'(v_o), 64'd1);
      check("early_data_o", data_o, 64'd0);
      ready_and_i = 1'b1;
      tick();
      ready_and_i = 1'b0;

      // Randomized traffic with random stalls.
      for (int t = 0; t < 24; t++) begin
         run_txn(1'($urandom), PAW'({$urandom, $urandom}), 2'($urandom), {$urandom, $urandom},
                 1'($urandom), {$urandom, $urandom}, int'($urandom_range(0, 3)));
      end

      // Asynchronous reset in the middle of a read data wait.
      v_i = 1'b1; w_i = 1'b0; addr_i = 40'h80; size_i = 2'd3;
      tick();
      v_i = 1'b0;
      mem_cmd_header_ready_and_i = 1'b1;
      tick();
      mem_cmd_header_ready_and_i = 1'b0;
      mem_resp_header_v_i = 1'b1; mem_resp_has_data_i = 1'b1;
      tick();
      mem_resp_header_v_i = 1'b0; mem_resp_has_data_i = 1'b0;
      check("pre_rst_data_rdy", 64'(mem_resp_data_ready_and_o), 64'd1);
      #2 reset_n_i = 1'b0;
      #1;
      check("arst_ready_and_o", 64'(ready_and_o), 64'd1);
      check("arst_valids", 64'({v_o, mem_cmd_header_v_o, mem_cmd_data_v_o}), 64'd0);
      check("arst_resp_rdy", 64'({mem_resp_header_ready_and_o, mem_resp_data_ready_and_o}), 64'd0);
      #2 reset_n_i = 1'b1;
      tick();
      run_txn(1'b0, 40'h88, 2'd3, 64'd0, 1'b1, 64'hFEDCBA98_76543210, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
